// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32I pipeline.
// Register enables/flushes, EX forwarding selects, memory wait/timeout FSM.
module hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 16,
  parameter int MAX_MEM_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic              memreadE,
  input  logic [REG_AW-1:0] rdM,
  input  logic              regwriteM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regwriteW,
  input  logic              pc_srcE,
  input  logic              mem_reqM,
  input  logic              mem_ackM,
  output logic              enPC,
  output logic              enIF_ID,
  output logic              enID_EX,
  output logic              enEX_MEM,
  output logic              enMEM_WB,
  output logic              flushIF_ID,
  output logic              flushID_EX,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              mem_timeout
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT
  } state_t;

  localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_MEM_WAIT - 1);

  state_t            state;
  state_t            state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nx;
  logic              timeout_set;
  logic              stall_inc;
  logic              flush_inc;

  logic memwait;
  logic loaduse;
  logic do_freeze;
  logic do_flush;
  logic do_bubble;

  assign memwait = mem_reqM & ~mem_ackM;
  assign loaduse = memreadE & (rdE != '0) &
                   ((rdE == rs1D) | (rdE == rs2D));

  // One-hot priority: freeze > branch flush > load-use bubble
  assign do_freeze = memwait;
  assign do_flush  = ~memwait & pc_srcE;
  assign do_bubble = ~memwait & ~pc_srcE & loaduse;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              wr_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              wr_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && rd_m != '0 && rd_m == rs)
      sel = 2'b10;
    else if (wr_w && rd_w != '0 && rd_w == rs)
      sel = 2'b01;
    return sel;
  endfunction

  assign forwardAE = rst ? 2'b00 :
    fwd_sel(rs1E, rdM, regwriteM, rdW, regwriteW);
  assign forwardBE = rst ? 2'b00 :
    fwd_sel(rs2E, rdM, regwriteM, rdW, regwriteW);

  always_comb begin
    enPC       = 1'b1;
    enIF_ID    = 1'b1;
    enID_EX    = 1'b1;
    enEX_MEM   = 1'b1;
    enMEM_WB   = 1'b1;
    flushIF_ID = 1'b0;
    flushID_EX = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (!rst) begin
      case (state)
        HALT: begin
          enPC     = 1'b0;
          enIF_ID  = 1'b0;
          enID_EX  = 1'b0;
          enEX_MEM = 1'b0;
          enMEM_WB = 1'b0;
        end
        RUN, MEM_WAIT: begin
          unique case (1'b1)
            do_freeze: begin
              enPC      = 1'b0;
              enIF_ID   = 1'b0;
              enID_EX   = 1'b0;
              enEX_MEM  = 1'b0;
              enMEM_WB  = 1'b0;
              stall_inc = 1'b1;
            end
            do_flush: begin
              flushIF_ID = 1'b1;
              flushID_EX = 1'b1;
              flush_inc  = 1'b1;
            end
            do_bubble: begin
              enPC       = 1'b0;
              enIF_ID    = 1'b0;
              flushID_EX = 1'b1;
              stall_inc  = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    wait_nx     = wait_cnt;
    timeout_set = 1'b0;
    case (state)
      RUN: begin
        if (memwait) begin
          state_nx = MEM_WAIT;
          wait_nx  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        // A dropped request counts as completion
        if (!memwait) begin
          state_nx = RUN;
          wait_nx  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx    = HALT;
          timeout_set = 1'b1;
        end else begin
          wait_nx = wait_cnt + WAIT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (timeout_set)
        mem_timeout <= 1'b1;
      if (stall_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: rule-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_hazard_ctrl;

  localparam int MAXW = 15;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic memreadE, regwriteM, regwriteW;
  logic pc_srcE, mem_reqM, mem_ackM;

  logic enPC, enIF_ID, enID_EX, enEX_MEM, enMEM_WB;
  logic flushIF_ID, flushID_EX;
  logic [1:0] forwardAE, forwardBE;
  logic [15:0] stall_cnt, flush_cnt;
  logic mem_timeout;

  logic enPC4, enIF_ID4, enID_EX4, enEX_MEM4, enMEM_WB4;
  logic flushIF_ID4, flushID_EX4;
  logic [1:0] forwardAE4, forwardBE4;
  logic [3:0] stall_cnt4, flush_cnt4;
  logic mem_timeout4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .memreadE(memreadE),
    .rdM(rdM), .regwriteM(regwriteM),
    .rdW(rdW), .regwriteW(regwriteW),
    .pc_srcE(pc_srcE), .mem_reqM(mem_reqM), .mem_ackM(mem_ackM),
    .enPC(enPC), .enIF_ID(enIF_ID), .enID_EX(enID_EX),
    .enEX_MEM(enEX_MEM), .enMEM_WB(enMEM_WB),
    .flushIF_ID(flushIF_ID), .flushID_EX(flushID_EX),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .memreadE(memreadE),
    .rdM(rdM), .regwriteM(regwriteM),
    .rdW(rdW), .regwriteW(regwriteW),
    .pc_srcE(pc_srcE), .mem_reqM(mem_reqM), .mem_ackM(mem_ackM),
    .enPC(enPC4), .enIF_ID(enIF_ID4), .enID_EX(enID_EX4),
    .enEX_MEM(enEX_MEM4), .enMEM_WB(enMEM_WB4),
    .flushIF_ID(flushIF_ID4), .flushID_EX(flushID_EX4),
    .forwardAE(forwardAE4), .forwardBE(forwardBE4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4),
    .mem_timeout(mem_timeout4)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model state: cycles actually lost, flushes taken, run of
  // consecutive un-acked memory cycles
  bit known  = 1'b0;
  bit halted = 1'b0;
  bit tmo    = 1'b0;
  int run_mw = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  function automatic logic [1:0] want_fwd(input logic [4:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    logic mw;
    logic lu;
    logic [4:0] een;
    logic [1:0] efl;
    logic [1:0] efa;
    logic [1:0] efb;
    mw  = mem_reqM & ~mem_ackM;
    lu  = memreadE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    een = 5'h1f;
    efl = 2'b00;
    efa = want_fwd(rs1E);
    efb = want_fwd(rs2E);
    if (rst) begin
      efa = 2'b00;
      efb = 2'b00;
    end else if (halted || mw) begin
      een = 5'h00;
    end else if (pc_srcE) begin
      efl = 2'b11;
    end else if (lu) begin
      een = 5'b00111;
      efl = 2'b01;
    end
    chk("m_en", {enPC, enIF_ID, enID_EX, enEX_MEM, enMEM_WB}, een);
    chk("m_en4", {enPC4, enIF_ID4, enID_EX4, enEX_MEM4, enMEM_WB4}, een);
    chk("m_flush", {flushIF_ID, flushID_EX}, efl);
    chk("m_flush4", {flushIF_ID4, flushID_EX4}, efl);
    chk("m_fwdA", forwardAE, efa);
    chk("m_fwdB", forwardBE, efb);
    if (known) begin
      chk("m_stall", stall_cnt, sat(m_stall, 16));
      chk("m_fcnt", flush_cnt, sat(m_flush, 16));
      chk("m_stall4", stall_cnt4, sat(m_stall, 4));
      chk("m_fcnt4", flush_cnt4, sat(m_flush, 4));
      chk("m_tmo", {mem_timeout, mem_timeout4}, {tmo, tmo});
    end
    if (rst) begin
      known   = 1'b1;
      halted  = 1'b0;
      tmo     = 1'b0;
      run_mw  = 0;
      m_stall = 0;
      m_flush = 0;
    end else if (!halted) begin
      if (mw) begin
        run_mw++;
        m_stall++;
        if (run_mw == MAXW) begin
          halted = 1'b1;
          tmo    = 1'b1;
        end
      end else begin
        run_mw = 0;
        if (pc_srcE) m_flush++;
        else if (lu) m_stall++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0;
    rdE = 0; rdM = 0; rdW = 0;
    memreadE = 0; regwriteM = 0; regwriteW = 0;
    pc_srcE = 0; mem_reqM = 0; mem_ackM = 0;
  endtask

  task automatic pulse_rst();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_en", {enPC, enIF_ID, enID_EX, enEX_MEM, enMEM_WB}, 5'h1f);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_tmo", mem_timeout, 0);
    tick();

    // load-use bubble
    memreadE = 1; rdE = 5; rs1D = 5;
    @(negedge clk);
    chk("lu_enPC", enPC, 0);
    chk("lu_enIF", enIF_ID, 0);
    chk("lu_flEX", flushID_EX, 1);
    chk("lu_enEX", enID_EX, 1);
    tick();
    idle();
    @(negedge clk);
    chk("lu_after", {enPC, enIF_ID, flushID_EX}, 3'b110);
    chk("lu_stall", stall_cnt, 1);
    tick();

    // branch beats load-use
    pulse_rst();
    pc_srcE = 1; memreadE = 1; rdE = 5; rs2D = 5;
    @(negedge clk);
    chk("br_fl", {flushIF_ID, flushID_EX}, 2'b11);
    chk("br_enPC", enPC, 1);
    tick();
    idle();
    @(negedge clk);
    chk("br_fcnt", flush_cnt, 1);
    chk("br_stall", stall_cnt, 0);
    tick();

    // memory wait, branch held until ack cycle
    pulse_rst();
    pc_srcE = 1; mem_reqM = 1;
    repeat (3) begin
      @(negedge clk);
      chk("mw_frz", {enPC, enIF_ID, enID_EX, enEX_MEM, enMEM_WB}, 5'h00);
      chk("mw_nofl", {flushIF_ID, flushID_EX}, 2'b00);
      tick();
    end
    mem_ackM = 1;
    @(negedge clk);
    chk("ack_en", {enPC, enIF_ID, enID_EX, enEX_MEM, enMEM_WB}, 5'h1f);
    chk("ack_fl", {flushIF_ID, flushID_EX}, 2'b11);
    tick();
    idle();
    @(negedge clk);
    chk("ack_stall", stall_cnt, 3);
    chk("ack_fcnt", flush_cnt, 1);
    chk("ack_run", enPC, 1);
    tick();

    // timeout into HALT
    pulse_rst();
    mem_reqM = 1;
    repeat (14) tick();
    @(negedge clk);
    chk("to_pre", mem_timeout, 0);
    tick();
    @(negedge clk);
    chk("to_set", mem_timeout, 1);
    chk("to_stall", stall_cnt, 15);
    tick();
    mem_reqM = 0; pc_srcE = 1; memreadE = 1; rdE = 5; rs1D = 5;
    @(negedge clk);
    chk("halt_en", {enPC, enIF_ID, enID_EX, enEX_MEM, enMEM_WB}, 5'h00);
    chk("halt_fl", {flushIF_ID, flushID_EX}, 2'b00);
    tick();
    @(negedge clk);
    chk("halt_frz", {stall_cnt, flush_cnt}, {16'd15, 16'd0});
    rst = 1;
    @(negedge clk);
    chk("halt_rst_en", enPC, 1);
    tick();
    rst = 0;
    idle();
    @(negedge clk);
    chk("post_rst", {stall_cnt, flush_cnt}, 32'd0);
    chk("post_tmo", mem_timeout, 0);
    tick();

    // forwarding
    rs1E = 7; rdM = 7; regwriteM = 1; rdW = 7; regwriteW = 1;
    @(negedge clk);
    chk("fwd_mem", forwardAE, 2'b10);
    tick();
    rdM = 0;
    @(negedge clk);
    chk("fwd_wb", forwardAE, 2'b01);
    chk("fwd_x0", forwardBE, 2'b00);
    tick();
    rdM = 7; regwriteM = 0; rs2E = 7;
    @(negedge clk);
    chk("fwd_nowr", forwardBE, 2'b01);
    tick();
    idle();

    // saturation on the narrow counter
    pulse_rst();
    memreadE = 1; rdE = 3; rs2D = 3;
    repeat (20) tick();
    idle();
    @(negedge clk);
    chk("sat4", stall_cnt4, 4'hf);
    chk("sat16", stall_cnt, 20);
    tick();
    memreadE = 1; rdE = 0; rs1D = 0;
    @(negedge clk);
    chk("lu_x0", enPC, 1);
    tick();

    // reset while in MEM_WAIT clears the wait count
    idle();
    mem_reqM = 1;
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    mem_reqM = 0;
    @(negedge clk);
    chk("rstmw_en", {enPC, enIF_ID, enID_EX, enEX_MEM, enMEM_WB}, 5'h1f);
    tick();
    mem_reqM = 1;
    repeat (14) tick();
    @(negedge clk);
    chk("rstmw_pre", mem_timeout, 0);
    tick();
    @(negedge clk);
    chk("rstmw_to", mem_timeout, 1);
    pulse_rst();

    // control-flag sweep, model-checked
    for (int i = 0; i < 32; i++) begin
      mem_reqM = i[0];
      mem_ackM = i[1];
      pc_srcE  = i[2];
      memreadE = i[3];
      rdE      = i[4] ? 5'd6 : 5'd0;
      rs1D     = 5'd6;
      rs1E     = 5'(i % 4);
      rdM      = 5'd1;
      regwriteM = i[1];
      rdW      = 5'd2;
      regwriteW = 1'b1;
      tick();
    end
    idle();
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
